// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - fetch bus and execute handshake between sequencer, instruction memory and datapath
//
// Signals:
//   mem_addr   : instruction fetch address           (sequencer -> memory)
//   mem_req    : fetch request, held until mem_ack   (sequencer -> memory)
//   mem_ack    : fetch data valid this cycle         (memory -> sequencer)
//   mem_rdata  : {opcode, operand} instruction word  (memory -> sequencer)
//   opcode     : latched opcode                      (sequencer -> datapath)
//   operand    : latched operand                     (sequencer -> datapath)
//   exec_start : one-cycle execute start pulse       (sequencer -> datapath)
//   exec_done  : datapath finished the instruction   (datapath -> sequencer)
// Modports: master = sequencer side, slave = memory/datapath side.

interface instr_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]   mem_addr;
    logic                    mem_req;
    logic                    mem_ack;
    logic [2*DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0]   opcode;
    logic [DATA_WIDTH-1:0]   operand;
    logic                    exec_start;
    logic                    exec_done;

    modport master (
        output mem_addr,
        output mem_req,
        input  mem_ack,
        input  mem_rdata,
        output opcode,
        output operand,
        output exec_start,
        input  exec_done
    );

    modport slave (
        input  mem_addr,
        input  mem_req,
        output mem_ack,
        output mem_rdata,
        input  opcode,
        input  operand,
        input  exec_start,
        output exec_done
    );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute sequencer with run/step control, halt opcode and watchdog
//
// Ports:
//   clk            : single clock, rising edge
//   reset          : synchronous, active-high
//   run            : level, 1 = free-run, 0 = stop at next instruction boundary
//   step           : pulse, executes one instruction while stopped in IDLE
//   pc             : current program counter value
//   pc_enable      : one-cycle pulse advancing the program counter
//   pc_read_enable : drives the PC onto the shared bus during FETCH
//   halted         : sticky, halt opcode decoded or watchdog fault
//   fault          : sticky, watchdog expired in FETCH or EXEC
//   instr_count    : retired instruction count, wraps
//   state_debug    : encoded FSM state (IDLE=0 .. HALT=5)
//   bus            : memory fetch bus and datapath execute handshake (master side)

module instr_sequencer #(
    parameter int         DATA_WIDTH     = 16,
    parameter logic [7:0] HALT_OPCODE    = 8'hFF,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  pc_enable,
    output logic                  pc_read_enable,
    output logic                  halted,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] instr_count,
    output logic [2:0]            state_debug,
    instr_sequencer_if.master     bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    // The wait counter holds the number of completed wait cycles, so the
    // TIMEOUT_CYCLES-th cycle in FETCH/EXEC is the one where it equals this.
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic       is_halt_op;
    logic       timeout;

    assign is_halt_op = (bus.opcode[DATA_WIDTH-1 -: 8] == HALT_OPCODE);

    // Ack/done on the last allowed cycle wins: timeout only fires without it.
    always_comb begin
        timeout = 1'b0;
        if (wait_cnt == WAIT_LIMIT) begin
            if (state == ST_FETCH && !bus.mem_ack)
                timeout = 1'b1;
            if (state == ST_EXEC && !bus.exec_done)
                timeout = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic. step is only looked at in IDLE, so a step pulse while
    // running or while a stepped instruction is in flight is simply dropped.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (run || step)
                    next_state = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.mem_ack)
                    next_state = ST_DECODE;
                else if (timeout)
                    next_state = ST_HALT;
            end
            ST_DECODE: begin
                if (is_halt_op)
                    next_state = ST_HALT;
                else
                    next_state = ST_EXEC;
            end
            ST_EXEC: begin
                if (bus.exec_done)
                    next_state = ST_ADVANCE;
                else if (timeout)
                    next_state = ST_HALT;
            end
            ST_ADVANCE: begin
                if (run)
                    next_state = ST_FETCH;
                else
                    next_state = ST_IDLE;
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state only (plus the latched opcode and the pc
    // input); mem_ack and exec_done never reach an output combinationally.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_addr   = '0;
        bus.exec_start = 1'b0;
        pc_read_enable = 1'b0;
        pc_enable      = 1'b0;
        halted         = 1'b0;
        state_debug    = state;
        case (state)
            ST_FETCH: begin
                bus.mem_req    = 1'b1;
                bus.mem_addr   = pc;
                pc_read_enable = 1'b1;
            end
            ST_DECODE: begin
                bus.exec_start = !is_halt_op;
            end
            ST_ADVANCE: begin
                pc_enable = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath registers: instruction latch, retire counter, sticky fault and
    // watchdog counter. The counter restarts on every state change, which
    // covers both entry to FETCH and entry to EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.opcode  <= '0;
            bus.operand <= '0;
            instr_count <= '0;
            fault       <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if (state == ST_FETCH && bus.mem_ack) begin
                bus.opcode  <= bus.mem_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
                bus.operand <= bus.mem_rdata[DATA_WIDTH-1:0];
            end

            if (state == ST_ADVANCE)
                instr_count <= instr_count + DATA_WIDTH'(1);

            if (timeout)
                fault <= 1'b1;

            if (state != next_state)
                wait_cnt <= '0;
            else if (state == ST_FETCH || state == ST_EXEC)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized self-checking bench for instr_sequencer
module tb_instr_sequencer;

    localparam int DW  = 16;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          step;
    logic [DW-1:0] pc;
    logic          pc_enable;
    logic          pc_read_enable;
    logic          halted;
    logic          fault;
    logic [DW-1:0] instr_count;
    logic [2:0]    state_debug;

    instr_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    instr_sequencer #(
        .DATA_WIDTH     (DW),
        .HALT_OPCODE    (8'hFF),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .step           (step),
        .pc             (pc),
        .pc_enable      (pc_enable),
        .pc_read_enable (pc_read_enable),
        .halted         (halted),
        .fault          (fault),
        .instr_count    (instr_count),
        .state_debug    (state_debug),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // Environment program counter: advances by 3 on each pc_enable.
    always_ff @(posedge clk) begin
        if (reset)
            pc <= '0;
        else if (pc_enable)
            pc <= pc + 16'd3;
    end

    int n_exec_start = 0;
    always_ff @(posedge clk) begin
        if (bus.exec_start)
            n_exec_start <= n_exec_start + 1;
    end

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic [15:0]   exp_count;
    logic [15:0]   exp_pc;
    logic [31:0]   last_word;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ctl"}, 32'({bus.mem_req, pc_read_enable, bus.exec_start, pc_enable, halted, fault}), 32'(0));
        check_eq({tag, "_addr"}, 32'(bus.mem_addr), 32'(0));
        check_eq({tag, "_instr"}, {bus.opcode, bus.operand}, 32'(0));
        check_eq({tag, "_count"}, 32'(instr_count), 32'(0));
        check_eq({tag, "_state"}, 32'(state_debug), 32'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; step = 1'b0;
        bus.mem_ack = 1'b0; bus.exec_done = 1'b0; bus.mem_rdata = '0;
        tick();
        tick();
        check_reset_state("rst");
        reset = 1'b0;
        exp_count = '0; exp_pc = '0; last_word = '0;
        tick();
        check_eq("rst_idle", 32'(state_debug), 32'(0));
    endtask

    // Runs one instruction starting in its first FETCH cycle. lat/elat are
    // wait cycles before ack/done; values >= TMO mean they never come.
    task automatic do_instr(input logic [31:0] word, input int lat, input int elat,
                            input bit run_after, input bit noise);
        int t0;
        bit halt_op;
        halt_op = (word[31:24] == 8'hFF);
        t0 = cyc;
        check_eq("fetch_state", 32'(state_debug), 32'(1));
        for (int i = 0; i < TMO; i++) begin
            check_eq("fetch_req", 32'({bus.mem_req, pc_read_enable}), 32'(3));
            check_eq("fetch_addr", 32'(bus.mem_addr), 32'(exp_pc));
            check_eq("fetch_hold", {bus.opcode, bus.operand}, last_word);
            check_eq("fetch_quiet", 32'({bus.exec_start, pc_enable, halted, fault}), 32'(0));
            bus.mem_ack   = (i == lat);
            bus.mem_rdata = (i == lat) ? word : $urandom;
            bus.exec_done = noise ? 1'($urandom) : 1'b0;
            step          = noise ? 1'($urandom) : 1'b0;
            tick();
            if (i == lat) break;
        end
        bus.mem_ack = 1'b0;
        if (lat >= TMO) begin
            check_eq("fwd_state", 32'(state_debug), 32'(5));
            check_eq("fwd_flags", 32'({halted, fault, bus.mem_req}), 32'(6));
            check_eq("fwd_count", 32'(instr_count), 32'(exp_count));
            return;
        end
        last_word = word;
        check_eq("dec_state", 32'(state_debug), 32'(2));
        check_eq("dec_time", 32'(cyc - t0), 32'(lat + 1));
        check_eq("dec_instr", {bus.opcode, bus.operand}, word);
        check_eq("dec_start", 32'(bus.exec_start), 32'(!halt_op));
        check_eq("dec_quiet", 32'({bus.mem_req, pc_enable, halted}), 32'(0));
        bus.mem_ack   = noise ? 1'($urandom) : 1'b0;
        bus.mem_rdata = $urandom;
        bus.exec_done = noise ? 1'($urandom) : 1'b0;
        run = run_after;
        tick();
        if (halt_op) begin
            check_eq("halt_state", 32'(state_debug), 32'(5));
            check_eq("halt_flags", 32'({halted, fault}), 32'(2));
            check_eq("halt_quiet", 32'({bus.exec_start, pc_enable, bus.mem_req}), 32'(0));
            check_eq("halt_count", 32'(instr_count), 32'(exp_count));
            bus.mem_ack = 1'b0; bus.exec_done = 1'b0; step = 1'b0;
            return;
        end
        for (int i = 0; i < TMO; i++) begin
            check_eq("exec_state", 32'(state_debug), 32'(3));
            check_eq("exec_quiet", 32'({bus.exec_start, pc_enable, bus.mem_req, halted}), 32'(0));
            check_eq("exec_hold", {bus.opcode, bus.operand}, word);
            bus.exec_done = (i == elat);
            bus.mem_ack   = noise ? 1'($urandom) : 1'b0;
            bus.mem_rdata = $urandom;
            step          = noise ? 1'($urandom) : 1'b0;
            tick();
            if (i == elat) break;
        end
        bus.exec_done = 1'b0;
        if (elat >= TMO) begin
            check_eq("ewd_state", 32'(state_debug), 32'(5));
            check_eq("ewd_flags", 32'({halted, fault, pc_enable}), 32'(6));
            check_eq("ewd_count", 32'(instr_count), 32'(exp_count));
            bus.mem_ack = 1'b0; step = 1'b0;
            return;
        end
        check_eq("adv_state", 32'(state_debug), 32'(4));
        check_eq("adv_pcen", 32'({pc_enable, bus.exec_start, bus.mem_req, fault}), 32'(8));
        check_eq("adv_time", 32'(cyc - t0), 32'(lat + elat + 3));
        exp_count = exp_count + 16'd1;
        exp_pc    = exp_pc + 16'd3;
        bus.mem_ack   = noise ? 1'($urandom) : 1'b0;
        bus.exec_done = noise ? 1'($urandom) : 1'b0;
        step          = noise ? 1'($urandom) : 1'b0;
        tick();
        bus.mem_ack = 1'b0; bus.exec_done = 1'b0; step = 1'b0;
        check_eq("post_state", 32'(state_debug), run_after ? 32'(1) : 32'(0));
        check_eq("post_count", 32'(instr_count), 32'(exp_count));
        check_eq("post_pcen", 32'(pc_enable), 32'(0));
    endtask

    task automatic hold_halted(input bit exp_fault, input int n);
        for (int i = 0; i < n; i++) begin
            run           = 1'($urandom);
            step          = 1'($urandom);
            bus.mem_ack   = 1'($urandom);
            bus.exec_done = 1'($urandom);
            bus.mem_rdata = $urandom;
            tick();
            check_eq("hold_state", 32'(state_debug), 32'(5));
            check_eq("hold_flags", 32'({halted, fault}), 32'({1'b1, exp_fault}));
            check_eq("hold_quiet", 32'({bus.mem_req, bus.exec_start, pc_enable}), 32'(0));
            check_eq("hold_count", 32'(instr_count), 32'(exp_count));
            check_eq("hold_instr", {bus.opcode, bus.operand}, last_word);
        end
        run = 1'b0; step = 1'b0; bus.mem_ack = 1'b0; bus.exec_done = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:24] == 8'hFF)
            w[31:24] = 8'h01;
        return w;
    endfunction

    initial begin
        int s0;
        reset = 1'b1; run = 1'b0; step = 1'b0;
        bus.mem_ack = 1'b0; bus.exec_done = 1'b0; bus.mem_rdata = '0;
        exp_count = '0; exp_pc = '0; last_word = '0;
        tick();
        tick();
        check_reset_state("rst_init");
        reset = 1'b0;
        tick();
        check_eq("idle_norun", 32'(state_debug), 32'(0));

        // Reset held two cycles in the middle of a FETCH.
        run = 1'b1;
        tick();
        check_eq("first_req", 32'(bus.mem_req), 32'(1));
        tick();
        check_eq("wait_req", 32'(bus.mem_req), 32'(1));
        reset = 1'b1;
        tick();
        check_reset_state("rst_mid1");
        run = 1'b0;
        tick();
        check_reset_state("rst_mid2");
        reset = 1'b0;
        tick();
        check_eq("rst_mid_idle", 32'(state_debug), 32'(0));

        // Free run, zero-wait memory and execute.
        run = 1'b1;
        tick();
        s0 = n_exec_start;
        do_instr(32'h1000_0000, 0, 0, 1'b1, 1'b0);
        do_instr(32'h7000_0010, 0, 0, 1'b1, 1'b0);
        do_instr(32'h2000_0000, 0, 0, 1'b0, 1'b0);
        check_eq("free_count", 32'(instr_count), 32'(3));
        check_eq("free_starts", 32'(n_exec_start - s0), 32'(3));

        // Memory latency of three wait cycles.
        run = 1'b1;
        tick();
        do_instr(32'h3000_1234, 3, 0, 1'b0, 1'b0);

        // Randomized latencies with noise on ignored inputs.
        run = 1'b1;
        tick();
        for (int k = 0; k < 24; k++)
            do_instr(rand_word(), $urandom_range(0, 5), $urandom_range(0, 5), k != 23, 1'b1);

        // Step mode: one instruction per pulse, extra pulses mid-instruction dropped.
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("step_idle", 32'({state_debug, bus.mem_req}), 32'(0));
            step = 1'b1;
            tick();
            step = 1'b0;
            do_instr(rand_word(), $urandom_range(0, 3), $urandom_range(1, 4), 1'b0, 1'b1);
            for (int i = 0; i < 3; i++) begin
                tick();
                check_eq("step_stop", 32'({state_debug, bus.mem_req}), 32'(0));
                check_eq("step_count", 32'(instr_count), 32'(exp_count));
            end
        end

        // Ack/done on the last allowed cycle wins over the watchdog.
        run = 1'b1;
        tick();
        do_instr(rand_word(), TMO - 1, 0, 1'b1, 1'b0);
        do_instr(rand_word(), 0, TMO - 1, 1'b0, 1'b0);
        check_eq("wd_edge_fault", 32'({fault, halted}), 32'(0));

        // Halt opcode.
        run = 1'b1;
        tick();
        do_instr(32'hFF00_00AB, 1, 0, 1'b1, 1'b0);
        hold_halted(1'b0, 6);
        do_reset();

        // Fetch watchdog: no ack ever.
        run = 1'b1;
        tick();
        do_instr(rand_word(), TMO, 0, 1'b1, 1'b0);
        hold_halted(1'b1, 4);
        do_reset();

        // Execute watchdog: no done ever.
        run = 1'b1;
        tick();
        do_instr(rand_word(), 0, TMO, 1'b1, 1'b0);
        hold_halted(1'b1, 4);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/decode/execute sequencer for the 16-bit processor. It owns the instruction cycle: it fetches a 32-bit instruction word at the current program counter and presents opcode and operand to the datapath. It starts and awaits execution, then issues exactly one `pc_enable` pulse per instruction to the program counter. It also provides run/step control, a halt opcode, instruction counting, and a bus/execute watchdog.

## Interface
- `DATA_WIDTH`, 16: width of PC, opcode, operand, mem_addr, instr_count
- `HALT_OPCODE`, 8'hFF: opcode[15:8] value that halts the core
- `TIMEOUT_CYCLES`, 64: maximum cycles spent waiting in FETCH or EXEC before fault; range 2..255
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `run` in 1: level; 1 = free-running, 0 = stop at next instruction boundary
- `step` in 1: pulse; executes one instruction when stopped
- `pc` in 16: current program counter value
- `mem_addr` out 16: instruction fetch address
- `mem_req` out 1: fetch request, held until acknowledged
- `mem_ack` in 1: fetch data valid this cycle
- `mem_rdata` in 32: [31:16] opcode, [15:0] operand
- `opcode` out 16: latched opcode
- `operand` out 16: latched operand
- `exec_start` out 1: 1-cycle pulse starting datapath execution
- `exec_done` in 1: datapath finished the current instruction
- `pc_enable` out 1: 1-cycle pulse advancing/jumping the PC
- `pc_read_enable` out 1: drives PC onto shared bus during fetch
- `halted` out 1: sticky; halt opcode or fault reached
- `fault` out 1: sticky; watchdog expired
- `instr_count` out 16: retired instruction count, wraps 0xFFFF→0
- `state_debug` out 3: encoded FSM state

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, ADVANCE=4, HALT=5.
- Reset → IDLE. All outputs 0, including opcode, operand, instr_count, halted and fault.
- IDLE:
  - run=1 → FETCH.
  - run=0 with step=1 → FETCH, and the step is marked active.
  - Otherwise stay in IDLE.
- FETCH:
  - mem_req=1, pc_read_enable=1, mem_addr=pc.
  - On mem_ack: latch opcode/operand from mem_rdata, go to DECODE. Zero-wait ack (same cycle as the first req cycle) is legal.
- DECODE:
  - opcode[15:8]==HALT_OPCODE → HALT. No exec_start, no pc_enable, instr_count unchanged.
  - Otherwise pulse exec_start and go to EXEC.
- EXEC: wait for exec_done, then go to ADVANCE. exec_done is sampled only in EXEC and ignored in every other state.
- ADVANCE:
  - pc_enable=1 and instr_count+1 this cycle.
  - run=1 → FETCH; else → IDLE, and the active step is cleared.
- HALT: halted=1. Only reset leaves HALT; run and step are ignored.
- Watchdog:
  - The wait counter clears on entry to FETCH and on entry to EXEC.
  - It increments on each cycle in that state without ack/done.
  - If no ack/done has arrived by the TIMEOUT_CYCLES-th cycle, go to HALT with fault=1 and halted=1.
  - Ack/done on the TIMEOUT_CYCLES-th cycle itself wins over the timeout.
- run falling mid-instruction: the current instruction completes through ADVANCE, then the FSM stops in IDLE.
- step while run=1, or while a stepped instruction is in progress: ignored, not queued.
- opcode/operand hold their value until the next mem_ack. They are not cleared on entering HALT.
- reset in any state, including mid-fetch with mem_req high: next cycle is IDLE with mem_req=0.

## Timing
- Minimum instruction time is 4 cycles: FETCH (ack same cycle) → DECODE → EXEC (done first cycle) → ADVANCE.
- Each mem wait cycle adds 1 cycle; each exec wait cycle adds 1 cycle.
- exec_start is asserted in the cycle after the accepting mem_ack.
- pc_enable is asserted in the cycle after exec_done is sampled.
- The new PC is visible on `pc` in the cycle after pc_enable. The next FETCH cycle uses that updated pc.
- From IDLE, the first mem_req is asserted in the cycle after run rises or step is sampled.
- halted rises in the cycle after the DECODE of a halt opcode, or after the timeout cycle.
- All outputs are registered or decoded purely from state; mem_ack/exec_done have no combinational path to outputs.

## Test plan
- Reset: hold reset 2 cycles mid-FETCH → all outputs 0, state_debug=0; mem_req drops the cycle after reset is sampled.
- Free run, zero-wait memory and exec_done tied 1, three non-halt instructions (0x1000, 0x7000 operand 0x0010, 0x2000) → pc_enable pulses every 4th cycle, instr_count=3, exec_start count=3.
- Memory latency 3 cycles (ack on the 4th FETCH cycle) → opcode latched on the ack cycle, instruction takes 7 cycles, mem_addr stable = pc throughout FETCH.
- Halt: fetch 0xFF00 → HALT, halted=1, no exec_start/pc_enable, instr_count unchanged; run/step toggles ignored until reset.
- Step mode, run=0: a single step pulse → exactly one instruction, back in IDLE with instr_count+1; a second step pulse during EXEC is ignored.
- Watchdog with TIMEOUT_CYCLES=64:
  - mem_ack never asserted → fault=1 and halted=1 after 64 FETCH cycles.
  - Repeat with ack on cycle 64 → no fault, normal DECODE.
